data_ram_lsu: RTL and testbench

//  Next-generation data memory for the RV32I core. Four byte-lane banks of parameterised depth.

---
 rtl/data_ram_lsu.sv | 112 +++++++++++
 tb/tb_data_ram_lsu.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/data_ram_lsu.sv
// Byte-laned data memory for the RV32I core: four 8-bit banks behind a valid/ready
// request channel, native LB/LH/LW/LBU/LHU/SB/SH/SW with fault detection and a registered response.
module data_ram_lsu #(
  parameter int unsigned        DEPTH_LOG2 = 10,
  parameter int unsigned        ADDR_W     = 32,
  parameter logic [ADDR_W-1:0]  BASE_ADDR  = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;

  logic [7:0]            bank [4][DEPTH];

  logic                  accept;
  logic [ADDR_W-1:0]     off;
  logic [DEPTH_LOG2-1:0] idx;
  logic [1:0]            lane;
  logic                  out_of_range;
  logic                  misaligned;
  logic                  fault;
  logic                  wr_en;
  logic [3:0]            be;
  logic [31:0]           wword;
  logic [31:0]           rword;
  logic [7:0]            rbyte;
  logic [15:0]           rhalf;
  logic [31:0]           load_data;

  assign req_ready = ~rsp_valid | rsp_ready;
  assign accept    = req_valid & req_ready;

  // Offset wraps modulo 2^ADDR_W, so addresses below the base land far out of range.
  assign off          = req_addr - BASE_ADDR;
  assign idx          = off[DEPTH_LOG2+1:2];
  assign lane         = off[1:0];
  assign out_of_range = (off >> (DEPTH_LOG2 + 2)) != '0;

  always_comb begin
    misaligned = 1'b0;
    be         = '0;
    wword      = req_wdata;
    case (req_size)
      2'b00: begin
        be    = 4'b0001 << lane;
        wword = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        misaligned = lane[0];
        be         = lane[1] ? 4'b1100 : 4'b0011;
        wword      = {2{req_wdata[15:0]}};
      end
      2'b10: begin
        misaligned = (lane != 2'b00);
        be         = 4'b1111;
      end
      default: misaligned = 1'b1;
    endcase
  end

  assign fault = misaligned | out_of_range;
  assign wr_en = accept & req_we & ~fault & rst_n;

  // Banks carry no reset; contents survive rst_n.
  for (genvar l = 0; l < 4; l++) begin : g_bank
    always_ff @(posedge clk) begin
      if (wr_en && be[l]) begin
        bank[l][idx] <= wword[8*l +: 8];
      end
    end
  end

  assign rword = {bank[3][idx], bank[2][idx], bank[1][idx], bank[0][idx]};
  assign rbyte = rword[{lane, 3'b000} +: 8];
  assign rhalf = lane[1] ? rword[31:16] : rword[15:0];

  always_comb begin
    load_data = rword;
    case (req_size)
      2'b00:   load_data = {{24{~req_unsigned & rbyte[7]}}, rbyte};
      2'b01:   load_data = {{16{~req_unsigned & rhalf[15]}}, rhalf};
      default: load_data = rword;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_rdata <= (fault || req_we) ? '0 : load_data;
      rsp_err   <= fault;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_data_ram_lsu.sv
// Bench for data_ram_lsu: directed vector table, multi-cycle stall/reset sequences,
// and randomized accesses against a byte-addressed little-endian memory model.
module tb_data_ram_lsu;

  localparam int unsigned DL2  = 6;
  localparam int unsigned CAP  = 4 << DL2;
  localparam logic [31:0] BASE = 32'h0000_1000;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  data_ram_lsu #(
    .DEPTH_LOG2(DL2),
    .ADDR_W    (32),
    .BASE_ADDR (BASE)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_we      (req_we),
    .req_size    (req_size),
    .req_unsigned(req_unsigned),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_rdata   (rsp_rdata),
    .rsp_err     (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0] mdl [CAP];

  typedef struct {
    string       name;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic void model(input logic we, input logic [1:0] size, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                output logic [31:0] rdata, output logic err);
    logic [31:0] off;
    int unsigned n;
    off   = addr - BASE;
    n     = 1 << size;
    rdata = '0;
    err   = (size == 2'd3) || ((off % n) != 0) || (off >= CAP);
    if (err) return;
    for (int unsigned i = 0; i < n; i++) begin
      if (we) mdl[off + i] = wdata[8*i +: 8];
      else    rdata = rdata | (32'(mdl[off + i]) << (8*i));
    end
    if (!we && !uns && n < 4 && rdata[8*n-1]) rdata = rdata | ~((32'd1 << (8*n)) - 32'd1);
  endfunction

  task automatic issue(input string name, input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err);
    req_valid    = 1'b1;
    req_we       = we;
    req_size     = size;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
    chk({name, " req_ready"}, 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk({name, " rsp_valid"}, 32'(rsp_valid), 32'd1);
    chk({name, " rsp_rdata"}, rsp_rdata, exp_rdata);
    chk({name, " rsp_err"}, 32'(rsp_err), 32'(exp_err));
  endtask

  task automatic issue_model(input string name, input logic we, input logic [1:0] size,
                             input logic uns, input logic [31:0] addr, input logic [31:0] wdata);
    logic [31:0] r;
    logic        e;
    model(we, size, uns, addr, wdata, r, e);
    issue(name, we, size, uns, addr, wdata, r, e);
  endtask

  task automatic add(input string name, input logic we, input logic [1:0] size, input logic uns,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [31:0] exp_rdata, input logic exp_err);
    vec_t v;
    v.name = name; v.we = we; v.size = size; v.uns = uns; v.addr = addr;
    v.wdata = wdata; v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    tbl.push_back(v);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] r;
    logic        e;
    logic [31:0] held;
    logic [31:0] a;
    logic [1:0]  sz;

    rst_n = 1'b0; rsp_ready = 1'b1; req_valid = 1'b0; req_we = 1'b0;
    req_size = 2'd0; req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
    chk("reset rsp_rdata", rsp_rdata, 32'd0);
    chk("reset rsp_err", 32'(rsp_err), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post-reset req_ready", 32'(req_ready), 32'd1);

    // Fill memory with known contents
    for (int unsigned w = 0; w < CAP / 4; w++)
      issue_model("init sw", 1'b1, 2'd2, 1'b0, BASE + 32'(4 * w), $urandom);

    // Directed vectors (expected values derived by hand)
    add("sw 10",        1, 2'd2, 0, BASE + 32'h10, 32'h8000_00FF, 32'h0,         0);
    add("lw 10",        0, 2'd2, 0, BASE + 32'h10, 32'h0,         32'h8000_00FF, 0);
    add("sb 13",        1, 2'd0, 0, BASE + 32'h13, 32'h1234_56AB, 32'h0,         0);
    add("lb 13",        0, 2'd0, 0, BASE + 32'h13, 32'h0,         32'hFFFF_FFAB, 0);
    add("lbu 13",       0, 2'd0, 1, BASE + 32'h13, 32'h0,         32'h0000_00AB, 0);
    add("lw 10 lanes",  0, 2'd2, 0, BASE + 32'h10, 32'h0,         32'hAB00_00FF, 0);
    add("sh 11 misal",  1, 2'd1, 0, BASE + 32'h11, 32'h0000_1234, 32'h0,         1);
    add("lw 10 unchg",  0, 2'd2, 0, BASE + 32'h10, 32'h0,         32'hAB00_00FF, 0);
    add("lw 12 misal",  0, 2'd2, 0, BASE + 32'h12, 32'h0,         32'h0,         1);
    add("size11",       0, 2'd3, 0, BASE + 32'h10, 32'h0,         32'h0,         1);
    add("lw cap",       0, 2'd2, 0, BASE + 32'(CAP), 32'h0,       32'h0,         1);
    add("lw below",     0, 2'd2, 0, BASE - 32'd4,  32'h0,         32'h0,         1);
    add("sw cap",       1, 2'd2, 0, BASE + 32'(CAP), 32'h1111_2222, 32'h0,       1);
    add("sh 12",        1, 2'd1, 0, BASE + 32'h12, 32'hFFFF_BEEF, 32'h0,         0);
    add("lh 12",        0, 2'd1, 0, BASE + 32'h12, 32'h0,         32'hFFFF_BEEF, 0);
    add("lhu 12",       0, 2'd1, 1, BASE + 32'h12, 32'h0,         32'h0000_BEEF, 0);
    add("lh 10",        0, 2'd1, 0, BASE + 32'h10, 32'h0,         32'h0000_00FF, 0);
    add("lb 10",        0, 2'd0, 0, BASE + 32'h10, 32'h0,         32'hFFFF_FFFF, 0);
    add("lw uns",       0, 2'd2, 1, BASE + 32'h10, 32'h0,         32'hBEEF_00FF, 0);
    add("sw last",      1, 2'd2, 0, BASE + 32'(CAP - 4), 32'hCAFE_F00D, 32'h0,   0);
    add("lw last",      0, 2'd2, 0, BASE + 32'(CAP - 4), 32'h0,   32'hCAFE_F00D, 0);

    foreach (tbl[i]) begin
      model(tbl[i].we, tbl[i].size, tbl[i].uns, tbl[i].addr, tbl[i].wdata, r, e);
      issue(tbl[i].name, tbl[i].we, tbl[i].size, tbl[i].uns, tbl[i].addr, tbl[i].wdata,
            tbl[i].exp_rdata, tbl[i].exp_err);
    end

    // Idle with rsp_ready=1: valid drops, data holds
    @(posedge clk); #1;
    chk("idle rsp_valid", 32'(rsp_valid), 32'd0);
    chk("idle rsp_rdata hold", rsp_rdata, 32'hCAFE_F00D);

    // Back-to-back store then load, rsp_valid high both cycles
    model(1'b1, 2'd2, 1'b0, BASE + 32'h20, 32'h11, r, e);
    issue("b2b sw", 1'b1, 2'd2, 1'b0, BASE + 32'h20, 32'h11, 32'h0, 1'b0);
    issue("b2b lw", 1'b0, 2'd2, 1'b0, BASE + 32'h20, 32'h0, 32'h11, 1'b0);

    // Backpressure: three stalled cycles, then drain while a new request waits
    @(posedge clk); #1;
    model(1'b0, 2'd2, 1'b0, BASE + 32'h10, 32'h0, held, e);
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = BASE + 32'h10; req_wdata = '0;
    @(posedge clk); #1;
    req_we = 1'b1; req_wdata = 32'h5555_AAAA;
    for (int unsigned c = 0; c < 3; c++) begin
      chk("stall req_ready", 32'(req_ready), 32'd0);
      chk("stall rsp_valid", 32'(rsp_valid), 32'd1);
      chk("stall rsp_rdata", rsp_rdata, held);
      chk("stall rsp_err", 32'(rsp_err), 32'd0);
      @(posedge clk); #1;
    end
    chk("stall end rsp_rdata", rsp_rdata, held);
    rsp_ready = 1'b1;
    #1;
    chk("drain req_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    model(1'b1, 2'd2, 1'b0, BASE + 32'h10, 32'h5555_AAAA, r, e);
    chk("drain rsp_valid", 32'(rsp_valid), 32'd1);
    chk("drain rsp_rdata", rsp_rdata, 32'h0);
    issue("after drain lw", 1'b0, 2'd2, 1'b0, BASE + 32'h10, 32'h0, 32'h5555_AAAA, 1'b0);

    // Reset while a response is pending and a store is presented
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = BASE + 32'h20;
    @(posedge clk); #1;
    chk("pre-rst rsp_valid", 32'(rsp_valid), 32'd1);
    chk("pre-rst rsp_rdata", rsp_rdata, 32'h11);
    req_we = 1'b1; req_wdata = 32'hDEAD_BEEF; rsp_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("rst rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst rsp_rdata", rsp_rdata, 32'd0);
    chk("rst rsp_err", 32'(rsp_err), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst release req_ready", 32'(req_ready), 32'd1);
    issue_model("post-rst lw", 1'b0, 2'd2, 1'b0, BASE + 32'h20, 32'h0);
    chk("post-rst old data", rsp_rdata, 32'h11);

    // Randomized accesses against the model
    for (int unsigned k = 0; k < 400; k++) begin
      sz = 2'($urandom_range(0, 3));
      a  = BASE + 32'($urandom_range(0, CAP + 15)) - 32'd8;
      if (sz != 2'd3 && $urandom_range(0, 3) != 0) a = a & ~(32'(1 << sz) - 32'd1);
      issue_model("rand", 1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom);
      if ($urandom_range(0, 7) == 0) begin
        @(posedge clk); #1;
        chk("rand idle rsp_valid", 32'(rsp_valid), 32'd0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
